// File: rtl/bmu_iter.sv
// -----------------------------------------------------------------------------
// bmu_iter -- iterative bit-manipulation unit.
//
// Computes carry-less multiply (CLMUL / CLMULH / CLMULR) and population count
// (CPOP) over XLEN/BITS_PER_CYCLE RUN cycles. Each RUN cycle consumes the next
// BITS_PER_CYCLE bits of the operand held in the right-shifting slice register.
// For CPOP, op1 is loaded into that register in place of op2, so the same
// slice feeds both the multiplier and the popcount.
//
// Ports:
//   s_clk_i      in   1     clock; all state updates on its rising edge
//   s_rst_i      in   1     synchronous active-high reset
//   s_start_i    in   1     start request (accepted in IDLE or DONE, no kill)
//   s_function_i in   2     0 CLMUL, 1 CLMULH, 2 CLMULR, 3 CPOP
//   s_op1_i      in   XLEN  operand 1
//   s_op2_i      in   XLEN  operand 2 (ignored for CPOP)
//   s_kill_i     in   1     flush: abort any operation, drop a same-cycle start
//   s_busy_o     out  1     high while in RUN
//   s_valid_o    out  1     single-cycle result strobe
//   s_result_o   out  XLEN  registered result, held until the next completion
// -----------------------------------------------------------------------------
module bmu_iter #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic            s_clk_i,
  input  logic            s_rst_i,
  input  logic            s_start_i,
  input  logic [1:0]      s_function_i,
  input  logic [XLEN-1:0] s_op1_i,
  input  logic [XLEN-1:0] s_op2_i,
  input  logic            s_kill_i,
  output logic            s_busy_o,
  output logic            s_valid_o,
  output logic [XLEN-1:0] s_result_o
);

  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    F_CLMUL  = 2'd0,
    F_CLMULH = 2'd1,
    F_CLMULR = 2'd2,
    F_CPOP   = 2'd3
  } func_e;

  state_e              state_q, state_d;
  func_e               func_q;
  logic [2*XLEN-1:0]   op1_sh_q;   // op1 pre-shifted to the current slice position
  logic [XLEN-1:0]     slice_sh_q; // op2 (or op1 for CPOP), consumed LSB first
  logic [2*XLEN-1:0]   acc_q, acc_next;
  logic [2*XLEN-1:0]   pop_cnt;
  logic [CNT_W-1:0]    cnt_q;
  logic [XLEN-1:0]     result_q, result_next;
  logic                valid_q;
  logic                start_ok;
  logic                last_run;

  // Start is refused while RUN is in flight and whenever kill is present.
  assign start_ok = s_start_i && !s_kill_i && (state_q != S_RUN);
  assign last_run = (state_q == S_RUN) && (cnt_q == LAST_CNT);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of block order.
  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: defaults are assigned first so no path leaves state_d unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RUN;
      S_RUN:   if (last_run) state_d = S_DONE;
      S_DONE:  state_d = start_ok ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (s_kill_i) state_d = S_IDLE;
  end

  // ---------------------------------------------------------------------------
  // Datapath: one slice per RUN cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    pop_cnt  = '0;
    acc_next = acc_q;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      pop_cnt = pop_cnt + {{(2*XLEN-1){1'b0}}, slice_sh_q[j]};
    end
    if (func_q == F_CPOP) begin
      acc_next = acc_q + pop_cnt;
    end else begin
      for (int j = 0; j < BITS_PER_CYCLE; j++) begin
        if (slice_sh_q[j]) acc_next = acc_next ^ (op1_sh_q << j);
      end
    end
  end

  // Result is taken from acc_next so the final slice lands in the same edge
  // that enters DONE.
  always_comb begin
    result_next = acc_next[XLEN-1:0];
    case (func_q)
      F_CLMULH: result_next = acc_next[2*XLEN-1:XLEN];
      F_CLMULR: result_next = acc_next[2*XLEN-2:XLEN-1];
      default:  result_next = acc_next[XLEN-1:0];
    endcase
  end

  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) begin
      func_q     <= F_CLMUL;
      op1_sh_q   <= '0;
      slice_sh_q <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (start_ok) begin
        func_q     <= func_e'(s_function_i);
        op1_sh_q   <= {{XLEN{1'b0}}, s_op1_i};
        slice_sh_q <= (func_e'(s_function_i) == F_CPOP) ? s_op1_i : s_op2_i;
        acc_q      <= '0;
        cnt_q      <= '0;
      end else if (state_q == S_RUN && !s_kill_i) begin
        acc_q      <= acc_next;
        op1_sh_q   <= op1_sh_q << BITS_PER_CYCLE;
        slice_sh_q <= slice_sh_q >> BITS_PER_CYCLE;
        cnt_q      <= cnt_q + CNT_W'(1);
        if (last_run) begin
          result_q <= result_next;
          valid_q  <= 1'b1;
        end
      end
    end
  end

  assign s_busy_o   = (state_q == S_RUN);
  assign s_valid_o  = valid_q;
  assign s_result_o = result_q;

endmodule

// File: tb/tb_bmu_iter.sv
// -----------------------------------------------------------------------------
// tb_bmu_iter -- directed self-checking bench for bmu_iter.
// Two instances: default (XLEN=32, 4 bits/cycle) and XLEN=64, 8 bits/cycle.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_bmu_iter;

  localparam logic [1:0] CLMUL  = 2'd0;
  localparam logic [1:0] CLMULH = 2'd1;
  localparam logic [1:0] CLMULR = 2'd2;
  localparam logic [1:0] CPOP   = 2'd3;

  logic        clk = 1'b0;
  logic        rst32, rst64;
  logic        start32, start64;
  logic [1:0]  fn;
  logic [63:0] op1, op2;
  logic        kill;

  logic        busy32, valid32;
  logic [31:0] result32;
  logic        busy64, valid64;
  logic [63:0] result64;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bmu_iter dut32 (
    .s_clk_i      (clk),
    .s_rst_i      (rst32),
    .s_start_i    (start32),
    .s_function_i (fn),
    .s_op1_i      (op1[31:0]),
    .s_op2_i      (op2[31:0]),
    .s_kill_i     (kill),
    .s_busy_o     (busy32),
    .s_valid_o    (valid32),
    .s_result_o   (result32)
  );

  bmu_iter #(.XLEN(64), .BITS_PER_CYCLE(8)) dut64 (
    .s_clk_i      (clk),
    .s_rst_i      (rst64),
    .s_start_i    (start64),
    .s_function_i (fn),
    .s_op1_i      (op1),
    .s_op2_i      (op2),
    .s_kill_i     (kill),
    .s_busy_o     (busy64),
    .s_valid_o    (valid64),
    .s_result_o   (result64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic get_busy(input bit u);
    return u ? busy64 : busy32;
  endfunction

  function automatic logic get_valid(input bit u);
    return u ? valid64 : valid32;
  endfunction

  function automatic logic [63:0] get_res(input bit u);
    return u ? result64 : {32'h0, result32};
  endfunction

  // Called on a falling edge; returns on the falling edge after the start edge.
  task automatic start_op(input bit u, input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
    fn  = f;
    op1 = a;
    op2 = b;
    if (u) start64 = 1'b1; else start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    start64 = 1'b0;
  endtask

  // cyc=1 is the cycle right after the start edge; valid is expected at cyc=9.
  task automatic wait_valid(input bit u, output int cyc, output int busy_cnt);
    cyc = 1;
    busy_cnt = 0;
    while (!get_valid(u) && cyc < 40) begin
      if (get_busy(u)) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic count_valids(input bit u, input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (get_valid(u)) cnt++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input bit u, input logic [1:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input string tag);
    int cyc, bc;
    start_op(u, f, a, b);
    wait_valid(u, cyc, bc);
    check({tag, "_lat"}, 64'(cyc), 64'd9);
    check({tag, "_res"}, get_res(u), exp);
    @(negedge clk);
    check({tag, "_valid_drop"}, 64'(get_valid(u)), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bc, nv;

    rst32 = 1'b1; rst64 = 1'b1;
    start32 = 1'b0; start64 = 1'b0;
    fn = CLMUL; op1 = '0; op2 = '0; kill = 1'b0;
    repeat (3) @(negedge clk);
    rst32 = 1'b0; rst64 = 1'b0;

    // Reset state
    check("rst_busy32",  64'(busy32), 64'd0);
    check("rst_valid32", 64'(valid32), 64'd0);
    check("rst_res32",   get_res(0), 64'd0);
    check("rst_busy64",  64'(busy64), 64'd0);
    check("rst_res64",   get_res(1), 64'd0);

    // CLMUL 3*3: latency 9, busy 8 cycles
    start_op(0, CLMUL, 64'd3, 64'd3);
    wait_valid(0, cyc, bc);
    check("clmul33_lat",  64'(cyc), 64'd9);
    check("clmul33_busy", 64'(bc), 64'd8);
    check("clmul33_busy_done", 64'(busy32), 64'd0);
    check("clmul33_res",  get_res(0), 64'h5);
    @(negedge clk);
    check("clmul33_valid_drop", 64'(valid32), 64'd0);

    // High-bit operands across the three CLMUL variants
    run_op(0, CLMULH, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, "clmulh_msb");
    run_op(0, CLMULR, 64'h8000_0000, 64'h8000_0000, 64'h8000_0000, "clmulr_msb");
    run_op(0, CLMUL,  64'h8000_0000, 64'h8000_0000, 64'h0,         "clmul_msb");
    run_op(0, CLMUL,  64'hFFFF_FFFF, 64'h3,         64'h1,         "clmul_ones3");
    run_op(0, CLMULH, 64'hFFFF_FFFF, 64'h3,         64'h1,         "clmulh_ones3");

    // CPOP: op2 carries garbage that must be ignored
    run_op(0, CPOP, 64'hFFFF_0000, 64'hDEAD_BEEF, 64'h10, "cpop_half");
    run_op(0, CPOP, 64'hFFFF_FFFF, 64'hDEAD_BEEF, 64'h20, "cpop_ones");
    run_op(0, CPOP, 64'h0,         64'hFFFF_FFFF, 64'h0,  "cpop_zero");

    // Establish a known result (5), then kill at RUN cycle 4
    run_op(0, CLMUL, 64'd3, 64'd3, 64'h5, "pre_kill");
    start_op(0, CPOP, 64'hFFFF_FFFF, 64'h0);
    repeat (3) @(negedge clk);
    check("kill_busy_before", 64'(busy32), 64'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_idle_busy",  64'(busy32), 64'd0);
    check("kill_idle_valid", 64'(valid32), 64'd0);
    count_valids(0, 12, nv);
    check("kill_no_valid", 64'(nv), 64'd0);
    check("kill_res_kept", get_res(0), 64'h5);

    // Start together with kill: nothing accepted
    fn = CPOP; op1 = 64'hFFFF_FFFF;
    start32 = 1'b1; kill = 1'b1;
    @(negedge clk);
    start32 = 1'b0; kill = 1'b0;
    check("startkill_busy", 64'(busy32), 64'd0);
    count_valids(0, 12, nv);
    check("startkill_no_valid", 64'(nv), 64'd0);
    check("startkill_res_kept", get_res(0), 64'h5);

    // Back-to-back: start in the DONE cycle of the first operation
    start_op(0, CLMUL, 64'd3, 64'd3);
    wait_valid(0, cyc, bc);
    check("b2b_first_lat", 64'(cyc), 64'd9);
    check("b2b_first_res", get_res(0), 64'h5);
    start_op(0, CLMUL, 64'd5, 64'd5);
    check("b2b_busy", 64'(busy32), 64'd1);
    wait_valid(0, cyc, bc);
    check("b2b_second_gap", 64'(cyc), 64'd9);
    check("b2b_second_res", get_res(0), 64'h11);
    @(negedge clk);

    // Start during RUN is ignored
    start_op(0, CLMUL, 64'd3, 64'd3);
    fn = CPOP; op1 = 64'hFFFF_FFFF;
    cyc = 1;
    while (!valid32 && cyc < 40) begin
      start32 = (cyc == 3);
      @(negedge clk);
      cyc++;
    end
    start32 = 1'b0;
    check("runstart_lat", 64'(cyc), 64'd9);
    check("runstart_res", get_res(0), 64'h5);
    @(negedge clk);
    count_valids(0, 15, nv);
    check("runstart_single_valid", 64'(nv), 64'd0);
    check("runstart_idle", 64'(busy32), 64'd0);

    // XLEN=64, 8 bits/cycle
    run_op(1, CLMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h5555_5555_5555_5555, "x64_clmulh");

    // Reset mid-RUN on the 64-bit instance
    start_op(1, CPOP, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    repeat (3) @(negedge clk);
    check("x64_rst_busy_before", 64'(busy64), 64'd1);
    rst64 = 1'b1;
    @(negedge clk);
    rst64 = 1'b0;
    check("x64_rst_busy",  64'(busy64), 64'd0);
    check("x64_rst_valid", 64'(valid64), 64'd0);
    check("x64_rst_res",   get_res(1), 64'h0);
    count_valids(1, 12, nv);
    check("x64_rst_no_valid", 64'(nv), 64'd0);

    run_op(1, CPOP, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'd64, "x64_cpop");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
